// File: rtl/sevenseg_pkg.sv
// Shared constants and glyph decode for the seven-segment scan decoder.
package sevenseg_pkg;

    localparam int NUM_DIGITS = 4;

    // Lit-segment patterns, bit order gfedcba
    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_A     = 7'h77;
    localparam logic [6:0] GLYPH_B     = 7'h7C;
    localparam logic [6:0] GLYPH_C     = 7'h39;
    localparam logic [6:0] GLYPH_D     = 7'h5E;
    localparam logic [6:0] GLYPH_E     = 7'h79;
    localparam logic [6:0] GLYPH_F     = 7'h71;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    localparam logic [15:0][6:0] GLYPHS = {
        GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
        GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] value;
    } glyph_t;

    typedef enum logic {ST_IDLE, ST_COLLECT} state_t;

    function automatic glyph_t decode_glyph(input logic [6:0] lit);
        glyph_t r;
        r       = '0;
        r.blank = (lit == GLYPH_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (lit == GLYPHS[i]) begin
                r.legal = 1'b1;
                r.value = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sevenseg_sync.sv
// Two-flop synchronizer; the first stage is exposed for change detection.
module sevenseg_sync #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] mid,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mid <= RST_VAL;
            q   <= RST_VAL;
        end else begin
            mid <= d;
            q   <= mid;
        end
    end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Recovers the four hex digits from a multiplexed seven-segment bus and
// publishes a coherent snapshot once every digit has been captured.
module sevenseg_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    input  logic        dp,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [3:0]  dp_seen,
    output logic        frame_done,
    output logic        frame_err,
    output logic        stale
);

    localparam int BUS_W = 12;
    localparam int CW    = $clog2(STABLE_CYCLES + 1);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] STAB_FIRE = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] STAB_MAX  = CW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);

    logic [BUS_W-1:0] bus_mid, bus_s;
    logic [3:0]       an_s;
    logic [6:0]       seg_s;
    logic             dp_s;

    // Idle bus (everything dark) is all ones, so reset the synchronizer there
    sevenseg_sync #(.WIDTH(BUS_W), .RST_VAL({BUS_W{1'b1}})) u_sync (
        .clk (clk),
        .clr (clr),
        .d   ({an, seg, dp}),
        .mid (bus_mid),
        .q   (bus_s)
    );

    assign an_s  = bus_s[11:8];
    assign seg_s = bus_s[7:1];
    assign dp_s  = bus_s[0];

    // Comparing against the first stage clears the count on the same edge the
    // new value lands in the output stage.
    logic [CW-1:0] stab_cnt;
    logic          fire;

    always_ff @(posedge clk or posedge clr) begin
        if (clr)                     stab_cnt <= '0;
        else if (bus_mid != bus_s)   stab_cnt <= '0;
        else if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + 1'b1;
    end

    assign fire = (stab_cnt == STAB_FIRE);

    logic [3:0] lit_an;
    logic       one_hot, blank_an;
    logic [1:0] idx;
    glyph_t     g;

    always_comb begin
        lit_an   = ~an_s;
        blank_an = (lit_an == 4'h0);
        one_hot  = !blank_an && ((lit_an & (lit_an - 4'd1)) == 4'h0);
        idx      = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (lit_an[i]) idx = 2'(i);
        g = decode_glyph(~seg_s);
    end

    logic       capture, ev_err, publish, err_acc, err_next;
    logic [3:0] seen_mask, mask_next;
    logic [3:0][3:0] shadow_val, shadow_val_next;
    logic [3:0] shadow_valid, shadow_valid_next, shadow_dp, shadow_dp_next;

    always_comb begin
        capture = fire && one_hot;
        ev_err  = fire && ((!one_hot && !blank_an) || (one_hot && !g.legal && !g.blank));
        err_next          = err_acc | ev_err;
        mask_next         = seen_mask;
        shadow_val_next   = shadow_val;
        shadow_valid_next = shadow_valid;
        shadow_dp_next    = shadow_dp;
        if (capture) begin
            mask_next[idx]         = 1'b1;
            shadow_val_next[idx]   = g.value;
            shadow_valid_next[idx] = g.legal;
            shadow_dp_next[idx]    = !dp_s;
        end
        publish = capture && (mask_next == 4'hF);
    end

    state_t          state;
    logic [3:0][3:0] digits_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state        <= ST_IDLE;
            seen_mask    <= '0;
            err_acc      <= 1'b0;
            shadow_val   <= '0;
            shadow_valid <= '0;
            shadow_dp    <= '0;
            digits_q     <= '0;
            digit_valid  <= '0;
            dp_seen      <= '0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            shadow_val   <= shadow_val_next;
            shadow_valid <= shadow_valid_next;
            shadow_dp    <= shadow_dp_next;
            frame_done   <= publish;
            seen_mask    <= mask_next;
            err_acc      <= err_next;
            case (state)
                ST_IDLE: begin
                    if (capture) state <= ST_COLLECT;
                end
                ST_COLLECT: begin
                    if (publish) begin
                        state       <= ST_IDLE;
                        digits_q    <= shadow_val_next;
                        digit_valid <= shadow_valid_next;
                        dp_seen     <= shadow_dp_next;
                        frame_err   <= err_next;
                        seen_mask   <= '0;
                        err_acc     <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign digits = digits_q;

    logic [TW-1:0] stale_cnt, stale_cnt_next;
    logic          any_capture;

    always_comb begin
        if (capture)                 stale_cnt_next = '0;
        else if (stale_cnt == TMO_MAX) stale_cnt_next = stale_cnt;
        else                         stale_cnt_next = stale_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stale_cnt   <= '0;
            any_capture <= 1'b0;
            stale       <= 1'b1;
        end else begin
            stale_cnt   <= stale_cnt_next;
            any_capture <= any_capture | capture;
            stale       <= !(any_capture | capture) || (stale_cnt_next == TMO_MAX);
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed bench: table of full scans plus hand-written multi-cycle corner cases.
module tb_sevenseg_scan_decoder;

    logic        clk = 1'b0;
    logic        clr;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic [15:0] digits;
    logic [3:0]  digit_valid, dp_seen;
    logic        frame_done, frame_err, stale;

    int checks   = 0;
    int failures = 0;
    int fd_count = 0;
    int fd_double = 0;
    logic fd_prev = 1'b0;

    always #5 clk = ~clk;

    sevenseg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
        .clk         (clk),
        .clr         (clr),
        .seg         (seg),
        .an          (an),
        .dp          (dp),
        .digits      (digits),
        .digit_valid (digit_valid),
        .dp_seen     (dp_seen),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .stale       (stale)
    );

    always @(negedge clk) begin
        if (frame_done) fd_count++;
        if (frame_done && fd_prev) fd_double++;
        fd_prev = frame_done;
    end

    typedef struct {
        logic [3:0][6:0] lit;
        logic [3:0]      dpm;
        logic [15:0]     exp_digits;
        logic [3:0]      exp_valid;
        logic [3:0]      exp_dp;
        logic            exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] lit, input logic d);
        an  = a;
        seg = ~lit;
        dp  = ~d;
    endtask

    task automatic blank_bus();
        drive(4'hF, 7'h00, 1'b0);
    endtask

    task automatic show(input int i, input logic [6:0] lit, input logic d, input int dwell);
        drive(4'(~(4'b1 << i)), lit, d);
        step(dwell);
        blank_bus();
        step(1);
    endtask

    task automatic scan1234();
        show(0, 7'h66, 1'b0, 8);
        show(1, 7'h4F, 1'b0, 8);
        show(2, 7'h5B, 1'b0, 8);
        show(3, 7'h06, 1'b0, 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0;
        vecs[0] = '{lit: {7'h06, 7'h5B, 7'h4F, 7'h66}, dpm: 4'b0000,
                    exp_digits: 16'h1234, exp_valid: 4'hF, exp_dp: 4'h0, exp_err: 1'b0};
        vecs[1] = '{lit: {7'h06, 7'h01, 7'h4F, 7'h66}, dpm: 4'b0000,
                    exp_digits: 16'h1034, exp_valid: 4'b1011, exp_dp: 4'h0, exp_err: 1'b1};
        vecs[2] = '{lit: {7'h77, 7'h7C, 7'h39, 7'h5E}, dpm: 4'b0000,
                    exp_digits: 16'hABCD, exp_valid: 4'hF, exp_dp: 4'h0, exp_err: 1'b0};
        vecs[3] = '{lit: {7'h6D, 7'h7D, 7'h00, 7'h07}, dpm: 4'b0000,
                    exp_digits: 16'h5607, exp_valid: 4'b1101, exp_dp: 4'h0, exp_err: 1'b0};
        vecs[4] = '{lit: {7'h71, 7'h79, 7'h6F, 7'h7F}, dpm: 4'b1010,
                    exp_digits: 16'hFE98, exp_valid: 4'hF, exp_dp: 4'b1010, exp_err: 1'b0};

        clr = 1'b1;
        blank_bus();
        step(3);
        clr = 1'b0;
        step(2);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_valid", 32'(digit_valid), 32'h0);
        chk("rst_dp", 32'(dp_seen), 32'h0);
        chk("rst_done", 32'(frame_done), 32'h0);
        chk("rst_err", 32'(frame_err), 32'h0);
        chk("rst_stale", 32'(stale), 32'h1);

        for (int v = 0; v < 5; v++) begin
            fd0 = fd_count;
            for (int d = 0; d < 4; d++) show(d, vecs[v].lit[d], vecs[v].dpm[d], 8);
            step(2);
            chk($sformatf("tbl%0d_done", v), 32'(fd_count), 32'(fd0 + 1));
            chk($sformatf("tbl%0d_digits", v), 32'(digits), 32'(vecs[v].exp_digits));
            chk($sformatf("tbl%0d_valid", v), 32'(digit_valid), 32'(vecs[v].exp_valid));
            chk($sformatf("tbl%0d_dp", v), 32'(dp_seen), 32'(vecs[v].exp_dp));
            chk($sformatf("tbl%0d_err", v), 32'(frame_err), 32'(vecs[v].exp_err));
            chk($sformatf("tbl%0d_stale", v), 32'(stale), 32'h0);
        end

        // Too-short dwell on digit 1 must not complete the frame
        fd0 = fd_count;
        show(0, 7'h66, 1'b0, 8);
        show(1, 7'h4F, 1'b0, 2);
        show(2, 7'h5B, 1'b0, 8);
        show(3, 7'h06, 1'b0, 8);
        step(2);
        chk("short_dwell_no_frame", 32'(fd_count), 32'(fd0));
        show(1, 7'h4F, 1'b0, 8);
        step(2);
        chk("short_dwell_frame", 32'(fd_count), 32'(fd0 + 1));
        chk("short_dwell_digits", 32'(digits), 32'h1234);

        // Two anodes low mid-scan
        fd0 = fd_count;
        show(0, 7'h66, 1'b0, 8);
        show(1, 7'h4F, 1'b0, 8);
        drive(4'b1100, 7'h3F, 1'b0);
        step(8);
        blank_bus();
        step(1);
        show(2, 7'h5B, 1'b0, 8);
        show(3, 7'h06, 1'b0, 8);
        step(2);
        chk("bad_an_frame", 32'(fd_count), 32'(fd0 + 1));
        chk("bad_an_err", 32'(frame_err), 32'h1);
        chk("bad_an_valid", 32'(digit_valid), 32'hF);
        scan1234();
        step(2);
        chk("bad_an_clean_err", 32'(frame_err), 32'h0);

        // Capture latency, dp, pulse width and stale timeout
        show(0, 7'h66, 1'b1, 8);
        show(1, 7'h4F, 1'b0, 8);
        show(2, 7'h5B, 1'b0, 8);
        drive(4'b0111, 7'h06, 1'b0);
        step(5);
        chk("latency_early", 32'(frame_done), 32'h0);
        step(1);
        chk("latency_done", 32'(frame_done), 32'h1);
        chk("dp_seen", 32'(dp_seen), 32'h1);
        chk("stale_after_cap", 32'(stale), 32'h0);
        blank_bus();
        step(1);
        chk("pulse_width", 32'(frame_done), 32'h0);
        step(62);
        chk("stale_63", 32'(stale), 32'h0);
        step(1);
        chk("stale_64", 32'(stale), 32'h1);
        chk("hold_digits", 32'(digits), 32'h1234);

        // Reset in the middle of a frame
        show(0, 7'h66, 1'b0, 8);
        show(1, 7'h4F, 1'b0, 8);
        show(2, 7'h5B, 1'b0, 8);
        clr = 1'b1;
        step(2);
        clr = 1'b0;
        step(1);
        chk("clr_digits", 32'(digits), 32'h0);
        chk("clr_valid", 32'(digit_valid), 32'h0);
        chk("clr_dp", 32'(dp_seen), 32'h0);
        chk("clr_err", 32'(frame_err), 32'h0);
        chk("clr_stale", 32'(stale), 32'h1);
        fd0 = fd_count;
        show(3, 7'h06, 1'b0, 8);
        step(2);
        chk("clr_partial_no_frame", 32'(fd_count), 32'(fd0));
        chk("clr_stale_cleared", 32'(stale), 32'h0);
        scan1234();
        step(2);
        chk("clr_full_frame", 32'(fd_count), 32'(fd0 + 1));
        chk("clr_full_digits", 32'(digits), 32'h1234);
        chk("done_single_cycle", 32'(fd_double), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
